// File: rtl/if_fetch_stage.sv
// Instruction-fetch / PC-generation stage: owns the fetch PC, issues one outstanding
// imem request at a time and hands PC/instruction pairs to decode through a one-entry skid.
module if_fetch_stage #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_trap,
  input  logic [N-1:0] i_trap_addr,
  input  logic         i_ret_trap,
  input  logic [N-1:0] i_ret_addr,
  input  logic         i_change_pc,
  input  logic [N-1:0] i_new_pc,
  input  logic         i_stall,
  output logic         o_imem_req,
  output logic [N-1:0] o_imem_addr,
  input  logic         i_imem_gnt,
  input  logic         i_imem_rvalid,
  input  logic [31:0]  i_imem_rdata,
  output logic [N-1:0] o_pc,
  output logic [31:0]  o_inst,
  output logic         o_valid,
  output logic         o_fetch_misaligned
);

  // Handshakes: imem request transfers on a cycle with o_imem_req && i_imem_gnt; the
  // response is i_imem_rvalid one or more cycles later. Decode takes o_pc/o_inst on a
  // cycle with o_valid && !i_stall; while stalled the outputs hold.
  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_FULL, S_FAULT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pend_pc, skid_pc;
  logic [31:0]  skid_inst;
  logic         kill;
  logic         redirect, misaligned, outstanding;
  logic [N-1:0] target;

  always_comb begin
    redirect = i_trap | i_ret_trap | i_change_pc;
    if (i_trap)          target = i_trap_addr;
    else if (i_ret_trap) target = i_ret_addr;
    else                 target = i_new_pc;
    misaligned = target[1:0] != 2'b00;
    // A granted request whose response has not yet arrived must be killed on redirect.
    outstanding = (state_q == S_WAIT  && !i_imem_rvalid) ||
                  (state_q == S_REQ   &&  i_imem_gnt)    ||
                  (state_q == S_FAULT &&  kill && !i_imem_rvalid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if (misaligned)       state_d = S_FAULT;
      else if (outstanding) state_d = S_WAIT;
      else                  state_d = S_REQ;
    end else begin
      unique case (state_q)
        S_BOOT:  state_d = S_REQ;
        S_REQ:   if (i_imem_gnt) state_d = S_WAIT;
        S_WAIT:  if (i_imem_rvalid) begin
                   if (kill || !o_valid || !i_stall) state_d = S_REQ;
                   else                              state_d = S_FULL;
                 end
        S_FULL:  if (!i_stall) state_d = S_REQ;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_comb begin
    o_imem_req  = (state_q == S_REQ);
    o_imem_addr = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q               <= RESET_PC;
      pend_pc            <= RESET_PC;
      skid_pc            <= RESET_PC;
      skid_inst          <= NOP;
      kill               <= 1'b0;
      o_pc               <= RESET_PC;
      o_inst             <= NOP;
      o_valid            <= 1'b0;
      o_fetch_misaligned <= 1'b0;
    end else if (redirect) begin
      pc_q      <= target;
      skid_pc   <= RESET_PC;
      skid_inst <= NOP;
      kill      <= outstanding;
      o_inst    <= NOP;
      // A misaligned target is reported straight away as a NOP carrying the bad PC.
      if (misaligned) begin
        o_pc               <= target;
        o_valid            <= 1'b1;
        o_fetch_misaligned <= 1'b1;
      end else begin
        o_valid            <= 1'b0;
        o_fetch_misaligned <= 1'b0;
      end
    end else begin
      if (o_valid && !i_stall && state_q != S_FAULT) o_valid <= 1'b0;
      unique case (state_q)
        S_REQ: if (i_imem_gnt) begin
          pend_pc <= pc_q;
          pc_q    <= pc_q + N'(4);
        end
        S_WAIT: if (i_imem_rvalid) begin
          if (kill) begin
            kill <= 1'b0;
          end else if (!o_valid || !i_stall) begin
            o_pc    <= pend_pc;
            o_inst  <= i_imem_rdata;
            o_valid <= 1'b1;
          end else begin
            skid_pc   <= pend_pc;
            skid_inst <= i_imem_rdata;
          end
        end
        S_FULL: if (!i_stall) begin
          o_pc    <= skid_pc;
          o_inst  <= skid_inst;
          o_valid <= 1'b1;
        end
        S_FAULT: if (i_imem_rvalid) kill <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a randomized run, all checked
// against a stream-level model (sequential PCs from the last redirect target).
module tb_if_fetch_stage;
  localparam int          N   = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_trap, i_ret_trap, i_change_pc, i_stall;
  logic [N-1:0] i_trap_addr, i_ret_addr, i_new_pc;
  logic         o_imem_req;
  logic [N-1:0] o_imem_addr;
  logic         i_imem_gnt, i_imem_rvalid;
  logic [31:0]  i_imem_rdata;
  logic [N-1:0] o_pc;
  logic [31:0]  o_inst;
  logic         o_valid, o_fetch_misaligned;

  always #5 clk = ~clk;

  if_fetch_stage #(.N(N), .RESET_PC('0), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_trap(i_trap), .i_trap_addr(i_trap_addr),
    .i_ret_trap(i_ret_trap), .i_ret_addr(i_ret_addr),
    .i_change_pc(i_change_pc), .i_new_pc(i_new_pc),
    .i_stall(i_stall),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_pc(o_pc), .o_inst(o_inst), .o_valid(o_valid),
    .o_fetch_misaligned(o_fetch_misaligned)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  mem [0:1023];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_next, fetch_exp, fault_pc, stable_addr, hold_pc;
  logic [31:0]  hold_inst;
  logic         faulted, stable_chk, hold_chk, seen_200;
  int           delivered;
  logic         gnt_always;
  int           lat_min, lat_max;
  logic         pend;
  logic [N-1:0] pend_addr;
  int           lat_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive the imem responder and check at the falling edge, update the model after the rising edge.
  task automatic tick();
    logic         p_req, p_gnt, p_rv, p_ov, p_stall, p_redir;
    logic [N-1:0] p_addr, p_pc, tgt;
    logic [31:0]  p_inst;
    logic [N-1:0] e;
    @(negedge clk);
    i_imem_rvalid = pend && (lat_cnt == 0);
    i_imem_rdata  = i_imem_rvalid ? mem[pend_addr[11:2]] : $urandom;
    i_imem_gnt    = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    p_redir = i_trap | i_ret_trap | i_change_pc;
    tgt     = i_trap ? i_trap_addr : (i_ret_trap ? i_ret_addr : i_new_pc);

    check("one_outstanding", 32'(o_imem_req && pend), 32'd0);
    if (stable_chk) begin
      check("req_held", 32'(o_imem_req), 32'd1);
      check("req_addr_stable", o_imem_addr, stable_addr);
    end
    if (hold_chk) begin
      check("stall_hold_valid", 32'(o_valid), 32'd1);
      check("stall_hold_pc", o_pc, hold_pc);
      check("stall_hold_inst", o_inst, hold_inst);
    end
    if (faulted) begin
      check("fault_valid", 32'(o_valid), 32'd1);
      check("fault_pc", o_pc, fault_pc);
      check("fault_inst", o_inst, NOP);
      check("fault_flag", 32'(o_fetch_misaligned), 32'd1);
      check("fault_no_req", 32'(o_imem_req), 32'd0);
    end else begin
      check("no_fault_flag", 32'(o_fetch_misaligned), 32'd0);
      if (!p_redir && o_valid && !i_stall) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(exp_next);
          exp_next = exp_next + 32'd4;
        end
        e = exp_q.pop_front();
        check("deliver_pc", o_pc, e);
        check("deliver_inst", o_inst, mem[e[11:2]]);
        delivered++;
      end
    end
    if (!p_redir && o_imem_req && i_imem_gnt) check("fetch_addr", o_imem_addr, fetch_exp);
    if (o_imem_req && o_imem_addr == 32'h200) seen_200 = 1'b1;

    p_req = o_imem_req; p_gnt = i_imem_gnt; p_rv = i_imem_rvalid; p_addr = o_imem_addr;
    p_ov = o_valid; p_stall = i_stall; p_pc = o_pc; p_inst = o_inst;
    @(posedge clk);
    #1;
    stable_chk  = p_req && !p_gnt && !p_redir;
    stable_addr = p_addr;
    hold_chk    = p_ov && p_stall && !p_redir && !faulted;
    hold_pc     = p_pc;
    hold_inst   = p_inst;
    if (p_req && p_gnt && !p_redir) fetch_exp = fetch_exp + 32'd4;
    if (p_rv) pend = 1'b0;
    else if (pend && lat_cnt > 0) lat_cnt--;
    if (p_req && p_gnt) begin
      pend      = 1'b1;
      pend_addr = p_addr;
      lat_cnt   = int'($urandom_range(lat_min, lat_max)) - 1;
    end
    if (p_redir) begin
      exp_q.delete();
      exp_next  = tgt;
      fetch_exp = tgt;
      faulted   = (tgt[1:0] != 2'b00);
      fault_pc  = tgt;
    end
  endtask

  task automatic clear_redirect();
    i_trap = 1'b0; i_ret_trap = 1'b0; i_change_pc = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (o_imem_req) break;
      tick();
    end
    check(tag, 32'(o_imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (o_valid) break;
      tick();
    end
    check(tag, 32'(o_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[2] = 32'h0050_0093;
    rst_n = 1'b0; i_stall = 1'b0; clear_redirect();
    i_trap_addr = '0; i_ret_addr = '0; i_new_pc = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    gnt_always = 1'b1; lat_min = 1; lat_max = 1;
    pend = 1'b0; pend_addr = '0; lat_cnt = 0;
    exp_next = '0; fetch_exp = '0; fault_pc = '0; faulted = 1'b0;
    stable_chk = 1'b0; hold_chk = 1'b0; stable_addr = '0; hold_pc = '0; hold_inst = '0;
    seen_200 = 1'b0; delivered = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_inst", o_inst, NOP);
    check("rst_misaligned", 32'(o_fetch_misaligned), 32'd0);
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_addr", o_imem_addr, 32'h0);
    rst_n = 1'b1;
    check("boot_no_req", 32'(o_imem_req), 32'd0);
    tick();
    check("first_req", 32'(o_imem_req), 32'd1);
    check("first_addr", o_imem_addr, 32'h0);

    // Fetch runs until PC 0x4 is presented
    for (int k = 0; k < 20; k++) begin
      if (o_valid && o_pc == 32'h4) break;
      tick();
    end
    check("t1_pc4", o_pc, 32'h4);
    check("t1_inst4", o_inst, mem[1]);
    check("t1_delivered", 32'(delivered), 32'd1);

    // Stall for 3 cycles: 0x4 holds, 0x8 lands in the skid, requests stop
    i_stall = 1'b1;
    repeat (3) begin
      tick();
      check("t2_hold_pc", o_pc, 32'h4);
      check("t2_no_req", 32'(o_imem_req), 32'd0);
    end
    lat_min = 3; lat_max = 3;
    i_stall = 1'b0;
    tick();
    check("t2_skid_valid", 32'(o_valid), 32'd1);
    check("t2_skid_pc", o_pc, 32'h8);
    check("t2_skid_inst", o_inst, 32'h0050_0093);

    // Branch to 0x100 while the 0xC fetch is outstanding
    tick();
    check("t3_outstanding", 32'(o_imem_req), 32'd0);
    i_change_pc = 1'b1; i_new_pc = 32'h100;
    tick();
    clear_redirect();
    check("t3_flush_valid", 32'(o_valid), 32'd0);
    check("t3_flush_inst", o_inst, NOP);
    wait_req("t3_req_seen");
    check("t3_req_addr", o_imem_addr, 32'h100);
    wait_valid("t3_valid_seen");
    check("t3_pc", o_pc, 32'h100);
    lat_min = 1; lat_max = 1;

    // Trap beats a simultaneous branch
    seen_200 = 1'b0;
    i_trap = 1'b1; i_trap_addr = 32'h80; i_change_pc = 1'b1; i_new_pc = 32'h200;
    tick();
    clear_redirect();
    wait_req("t4_req_seen");
    check("t4_req_addr", o_imem_addr, 32'h80);
    wait_valid("t4_valid_seen");
    check("t4_pc", o_pc, 32'h80);

    // Fill the skid under stall, then mret flushes it
    i_stall = 1'b1;
    repeat (8) tick();
    check("t5_full_no_req", 32'(o_imem_req), 32'd0);
    check("t5_full_pc", o_pc, 32'h80);
    check("t4_no_200", 32'(seen_200), 32'd0);
    i_ret_trap = 1'b1; i_ret_addr = 32'h40;
    tick();
    clear_redirect();
    check("t5_flush_valid", 32'(o_valid), 32'd0);
    i_stall = 1'b0;
    wait_valid("t5_valid_seen");
    check("t5_pc", o_pc, 32'h40);

    // Misaligned branch target faults until a trap redirect
    i_change_pc = 1'b1; i_new_pc = 32'h102;
    tick();
    clear_redirect();
    check("t6_valid", 32'(o_valid), 32'd1);
    check("t6_pc", o_pc, 32'h102);
    check("t6_inst", o_inst, NOP);
    check("t6_flag", 32'(o_fetch_misaligned), 32'd1);
    check("t6_no_req", 32'(o_imem_req), 32'd0);
    repeat (5) begin
      i_stall = 1'($urandom_range(0, 1));
      tick();
    end
    i_stall = 1'b0;
    i_trap = 1'b1; i_trap_addr = 32'h80;
    tick();
    clear_redirect();
    check("t6_exit_flag", 32'(o_fetch_misaligned), 32'd0);
    check("t6_exit_valid", 32'(o_valid), 32'd0);
    wait_valid("t6_resume_seen");
    check("t6_resume_pc", o_pc, 32'h80);
    check("t6_resume_inst", o_inst, mem[32]);

    // Randomized traffic: random grants, latencies, stalls and redirects
    gnt_always = 1'b0; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      i_stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < 4) begin
        i_trap      = ($urandom_range(0, 2) == 0);
        i_ret_trap  = ($urandom_range(0, 2) == 0);
        i_change_pc = 1'b1;
        i_trap_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
        i_ret_addr  = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
        i_new_pc    = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
      end
      tick();
      clear_redirect();
    end
    check("rand_progress", 32'(delivered > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
